seg7_scan_driver: RTL and testbench

- Time-multiplexed 7-segment display driver for the 4-digit, common-anode board display; sits directly downstream of the binary-to-BCD stage.
- Consumes the BCD `tens`/`ones` digits produced from the 5-bit adder sum and drives segment/anode lines.
- Captures new digit values on a load strobe. Commits them only at a scan-frame boundary so a displayed frame never mixes old and new values.

---
 rtl/seg7_scan_driver.sv | 115 +++++++++++
 tb/tb_seg7_scan_driver.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scanner with frame-aligned digit commit.
// Slot 0 shows ones, slot 1 shows tens, slots 2/3 stay dark.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       load,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       updated
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [3:0]    r_pend_t;
  logic [3:0]    r_pend_o;
  logic          r_pend;
  logic [3:0]    r_disp_t;
  logic [3:0]    r_disp_o;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;
  logic          r_upd;

  logic w_tick;
  logic w_frame;
  logic w_blank;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    s = 7'b0111111;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign w_tick  = (r_cnt == LAST);
  assign w_frame = w_tick && (r_idx == 2'd3);
  assign w_blank = BLANK_LZ && (r_disp_t == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_idx    <= 2'd0;
      r_pend_t <= 4'd0;
      r_pend_o <= 4'd0;
      r_pend   <= 1'b0;
      r_disp_t <= 4'd0;
      r_disp_o <= 4'd0;
      r_seg    <= 7'h7F;
      r_an     <= 4'hF;
      r_upd    <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick)
        r_idx <= r_idx + 2'd1;

      r_upd <= w_frame && (load || r_pend);

      // A load landing on the boundary bypasses the pending regs
      if (w_frame && load) begin
        r_disp_t <= tens;
        r_disp_o <= ones;
        r_pend   <= 1'b0;
      end else if (w_frame && r_pend) begin
        r_disp_t <= r_pend_t;
        r_disp_o <= r_pend_o;
        r_pend   <= 1'b0;
      end else if (load) begin
        r_pend_t <= tens;
        r_pend_o <= ones;
        r_pend   <= 1'b1;
      end

      case (r_idx)
        2'd0: begin
          r_an  <= 4'b1110;
          r_seg <= dec7(r_disp_o);
        end
        2'd1: begin
          r_an  <= w_blank ? 4'hF : 4'b1101;
          r_seg <= w_blank ? 7'h7F : dec7(r_disp_t);
        end
        default: begin
          r_an  <= 4'hF;
          r_seg <= 7'h7F;
        end
      endcase
    end
  end

  assign seg     = r_seg;
  assign an      = r_an;
  assign dp      = 1'b1;
  assign updated = r_upd;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (leading-zero blanking on/off)
// compared each cycle against a cycle-count based reference model.
module tb_seg7_scan_driver;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       load;
  logic [6:0] seg0, seg1;
  logic [3:0] an0, an1;
  logic       dp0, dp1;
  logic       upd0, upd1;

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) u_blank (
    .clk(clk), .rst_n(rst_n), .tens(tens), .ones(ones), .load(load),
    .seg(seg0), .an(an0), .dp(dp0), .updated(upd0)
  );

  seg7_scan_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) u_show (
    .clk(clk), .rst_n(rst_n), .tens(tens), .ones(ones), .load(load),
    .seg(seg1), .an(an1), .dp(dp1), .updated(upd1)
  );

  typedef struct {
    logic [6:0] s0;
    logic [3:0] a0;
    logic [6:0] s1;
    logic [3:0] a1;
    logic       u;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  bit started = 0;

  logic [6:0] font [16];
  initial begin
    font[0] = 7'b1000000; font[1] = 7'b1111001;
    font[2] = 7'b0100100; font[3] = 7'b0110000;
    font[4] = 7'b0011001; font[5] = 7'b0010010;
    font[6] = 7'b0000010; font[7] = 7'b1111000;
    font[8] = 7'b0000000; font[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) font[i] = 7'b0111111;
  end

  // Model: everything follows from the number of cycles since reset.
  int         m_c;
  bit         m_pend;
  logic [3:0] m_pt, m_po, m_dt, m_do;

  always @(posedge clk) begin
    exp_t e;
    int   slot;
    bit   bnd;
    if (!rst_n) begin
      m_c = 0; m_pend = 0;
      m_pt = 0; m_po = 0; m_dt = 0; m_do = 0;
      e = '{7'h7F, 4'hF, 7'h7F, 4'hF, 1'b0};
    end else begin
      slot = (m_c / DIV) % 4;
      bnd  = (m_c % FRAME) == FRAME - 1;
      e = '{7'h7F, 4'hF, 7'h7F, 4'hF, 1'b0};
      if (slot == 0) begin
        e.s0 = font[m_do]; e.a0 = 4'b1110;
        e.s1 = font[m_do]; e.a1 = 4'b1110;
      end else if (slot == 1) begin
        e.s1 = font[m_dt]; e.a1 = 4'b1101;
        if (m_dt != 0) begin
          e.s0 = font[m_dt]; e.a0 = 4'b1101;
        end
      end
      e.u = bnd && (load || m_pend);
      if (load) begin
        m_pt = tens; m_po = ones; m_pend = 1;
      end
      if (bnd && m_pend) begin
        m_dt = m_pt; m_do = m_po; m_pend = 0;
      end
      m_c++;
    end
    q.push_back(e);
    started = 1;
  end

  function automatic void chk(string nm, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, req);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      if (q.size() == 0) begin
        chk("queue_empty", 0, 1);
      end else begin
        e = q.pop_front();
        chk("seg_blank", seg0, e.s0);
        chk("an_blank", an0, e.a0);
        chk("seg_show", seg1, e.s1);
        chk("an_show", an1, e.a1);
        chk("upd_blank", upd0, e.u);
        chk("upd_show", upd1, e.u);
        chk("dp", {dp0, dp1}, 2'b11);
        chk("one_anode", int'($countones(~an0) <= 1), 1);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(logic [3:0] t, logic [3:0] o);
    tens = t; ones = o; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic at_phase(int ph);
    int k;
    k = 0;
    while ((m_c % FRAME) != ph && k < 2 * FRAME) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2 * FRAME) chk("phase_timeout", k, 0);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b1; tens = 4'd3; ones = 4'd1;
    cyc(3);
    rst_n = 1'b1; load = 1'b0;
    cyc(20);
    pulse(4'd3, 4'd1);
    cyc(40);
    pulse(4'd1, 4'd2);
    cyc(20);
    at_phase(6);
    pulse(4'd2, 4'd5);
    cyc(40);
    at_phase(5);
    pulse(4'd0, 4'd7);
    at_phase(9);
    pulse(4'd1, 4'd9);
    cyc(30);
    at_phase(FRAME - 1);
    pulse(4'd3, 4'd0);
    cyc(20);
    pulse(4'd0, 4'd9);
    cyc(40);
    pulse(4'hA, 4'd5);
    cyc(20);
    at_phase(6);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(20);
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      load  = ($urandom_range(0, 5) == 0);
      tens  = 4'($urandom_range(0, 15));
      ones  = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    rst_n = 1'b1; load = 1'b0;
    cyc(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
